uart_tx_fifo: RTL

Single-clock, first-word-fall-through byte FIFO that feeds the UART transmitter. The host/peripheral bus side pushes bytes into it. The transmitter pops bytes through the tx_data / tx_empty / tx_rden interface, sampling tx_data in the same cycle it asserts tx_rden. The block also provides occupancy, almost-full, overflow and flush support so software can pace writes.

---
 rtl/uart_tx_fifo.sv | 117 +++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO that feeds the UART transmitter.
// Status outputs come from the registered occupancy only, so they have no path from wr_en or tx_rden.
module uart_tx_fifo #(
   parameter int DEPTH        = 16,
   parameter int AFULL_THRESH = DEPTH - 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [7:0]                 wr_data,
   output logic                       full,
   output logic                       almost_full,
   output logic                       overflow,
   input  logic                       ovf_clr,
   input  logic                       flush,
   output logic [$clog2(DEPTH):0]     count,
   output logic [7:0]                 tx_data,
   output logic                       tx_empty,
   input  logic                       tx_rden
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);
   localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          overflow_r;

   logic          full_s;
   logic          empty_s;
   logic          push_s;
   logic          pop_s;
   logic          drop_s;
   logic [7:0]    tx_data_s;

   // Qualify requests against registered occupancy; flush overrides push, pop and drop.
   always_comb begin
      full_s    = (count_r == DEPTH_C);
      empty_s   = (count_r == ZERO_C);
      push_s    = 1'b0;
      pop_s     = 1'b0;
      drop_s    = 1'b0;
      tx_data_s = 8'h00;
      if (!flush) begin
         push_s = wr_en & ~full_s;
         pop_s  = tx_rden & ~empty_s;
         drop_s = wr_en & full_s;
      end else begin
         push_s = 1'b0;
         pop_s  = 1'b0;
         drop_s = 1'b0;
      end
      if (!empty_s) begin
         tx_data_s = mem_r[rd_ptr_r];
      end else begin
         tx_data_s = 8'h00;
      end
   end

   // Storage array; contents need no reset because tx_data is masked while empty.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= ZERO_C;
      end else if (flush) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= ZERO_C;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + ONE_C;
            2'b01:   count_r <= count_r - ONE_C;
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky overflow; a dropped push wins over a coincident clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end else if (ovf_clr) begin
         overflow_r <= 1'b0;
      end
   end

   assign full        = full_s;
   assign almost_full = (count_r >= AFULL_C);
   assign overflow    = overflow_r;
   assign count       = count_r;
   assign tx_empty    = empty_s;
   assign tx_data     = tx_data_s;

endmodule
